uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, 8N1 by default, the receiving end of the team's UART transmitter link. Synchronises the asynchronous `rx` pin, detects and validates the start bit, samples each bit at its centre using a bit-period counter, and presents each received byte as a single-cycle `rvalid` pulse. It sits between the board RX pin and the byte consumer, such as a command decoder or FIFO.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200); legal range ≥ 4.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset; synchronous, active-low.
- `rx`  input  1  asynchronous serial line; idles high.
- `rdata`  output  8  last good byte; LSB is the first data bit received.
- `rvalid`  output  1  one-cycle pulse when a frame with a valid stop bit completes.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  output  1  one-cycle pulse together with `rvalid` when parity mismatches; tied 0 when parity is compiled out.

## Operation
- **Input synchroniser:** 2-FF, both stages reset to 1. `rx_s` is the stage-2 output.
- **Bit counter:** `bcnt`, width `$clog2(CLKS_PER_BIT)`, counts 0..CLKS_PER_BIT-1.
- **Derived constant:** HALF = CLKS_PER_BIT/2, truncated.
- **Data counter:** `dcnt` is 3 bits, 0..7.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- **IDLE:** when `rx_s`==0, go to START with `bcnt`=0.
- **START:** at `bcnt`==HALF-1:
  - if `rx_s`==0, go to DATA with `bcnt`=0 and `dcnt`=0;
  - otherwise treat it as a glitch and return to IDLE, with no output pulse.
- **DATA:** at `bcnt`==CLKS_PER_BIT-1:
  - shift `rx_s` into the MSB of the shift register (right shift, LSB-first line order) and set `bcnt`=0;
  - after `dcnt`==7, go to PARITY, or to STOP without the macro.
- **PARITY:** at `bcnt`==CLKS_PER_BIT-1, latch `rx_s` as the parity bit and go to STOP.
- **STOP:** at `bcnt`==CLKS_PER_BIT-1:
  - if `rx_s`==1: load `rdata` from the shift register, pulse `rvalid`, pulse `parity_err` if a mismatch was found, then go to IDLE;
  - if `rx_s`==0: pulse `frame_err`, leave `rdata` unchanged, go to BREAK.
- **BREAK:** stay until `rx_s`==1, then go to IDLE. A held-low line therefore never produces repeated frames.
- **No flow control:** the consumer must capture `rdata` during `rvalid`. `rdata` holds until the next good frame.
- **Reset values** (also applied on any mid-frame reset): FSM = IDLE, `rdata`=0, `rvalid`=0, `frame_err`=0, `parity_err`=0, `bcnt`=0, `dcnt`=0, shift register 0, both sync FFs = 1. A partially received frame is discarded.

## Timing
- **Reference edge:** E0 is the first clk edge that samples `rx` low into sync stage 1. The FSM enters START at E0+2.
- **Start validation:** START→DATA happens at edge E0+2+HALF.
- **Data sampling:** data bit i (0..7) is sampled at E0+2+HALF+(i+1)·CLKS_PER_BIT, which is mid-bit.
- **Stop sampling:** the stop bit is sampled at E0+2+HALF+9·CLKS_PER_BIT; parity adds one CLKS_PER_BIT.
- **Output timing:** `rvalid`, `rdata`, `frame_err` and `parity_err` are registered at the stop-sample edge. They are high for exactly the one following cycle.
- **Back-to-back frames:** a start bit that immediately follows a stop bit is accepted. The FSM is back in IDLE HALF cycles before that stop bit ends.
- **Glitches:** a low pulse shorter than HALF-2 cycles is rejected.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - the frame is 11 bits (start, 8 data, even parity, stop) and the PARITY state exists;
  - `parity_err` = 1 when the XOR of the 8 data bits and the parity bit is 1;
  - data is still delivered with `rvalid`.
- **Undefined:**
  - 8N1 frame with no PARITY state;
  - `parity_err` is constant 0.

## Structure
- **Package `uart_pkg`:**
  - FSM state typedef `uart_rx_state_t`;
  - `UART_DATA_BITS`=8;
  - default `UART_CLKS_PER_BIT`=868;
  - shared with the transmitter.
- **Sub-module `uart_sync2`:** 2-FF synchroniser with parameterised reset value (1 here). `uart_receiver` instantiates it once on `rx`.

## Test plan
- **Clean byte:** `CLKS_PER_BIT`=16, send 0xA5 8N1 → one `rvalid` pulse, `rdata`=0xA5, both error flags 0, `rvalid` exactly one cycle.
- **Back-to-back frames:** send 0x00, 0xFF, 0x3C with no idle gap → three `rvalid` pulses, in order, 160 cycles apart.
- **Glitch rejection:** `rx` low for 4 cycles then high → no `rvalid`, FSM back in IDLE, no pulses.
- **Stop error and break:** send 0x55 with the stop bit low, then hold `rx` low for 40 bit times → exactly one `frame_err`, no `rvalid`, `rdata` keeps its previous value. After `rx` goes high, send 0x12 → `rvalid` with `rdata`=0x12.
- **Reset mid-frame:** assert `rst`=0 for 1 cycle after data bit 3 of 0x81 → no output pulses, `rdata`=0. The next frame, 0x7E, is received correctly.
- **Parity (`UART_RX_PARITY_EN`):**
  - send 0x07 with parity bit 1 → `rvalid`, `parity_err`=0;
  - send 0x07 with parity bit 0 → `rvalid` and `parity_err` pulse together, `rdata`=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver FSM state encoding and a parity helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  // Plain vector encoding keeps the states visible on a debug port and in old netlists.
  typedef logic [2:0] uart_rx_state_t;

  localparam uart_rx_state_t ST_IDLE   = 3'd0;
  localparam uart_rx_state_t ST_START  = 3'd1;
  localparam uart_rx_state_t ST_DATA   = 3'd2;
  localparam uart_rx_state_t ST_PARITY = 3'd3;
  localparam uart_rx_state_t ST_STOP   = 3'd4;
  localparam uart_rx_state_t ST_BREAK  = 3'd5;

  // Even parity: the data bits together with the parity bit must XOR to 0.
  function automatic logic even_parity_mismatch(input logic [UART_DATA_BITS-1:0] data,
                                                input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte output bundle of the UART receiver.
// Handshake: rvalid is a one-cycle pulse with no back-pressure; the consumer captures rdata in that cycle.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rdata;
  logic                      rvalid;
  logic                      frame_err;
  logic                      parity_err;

  modport master (output rdata, output rvalid, output frame_err, output parity_err);
  modport slave  (input  rdata, input  rvalid, input  frame_err, input  parity_err);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input with a configurable reset level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for an 8E1 frame with parity checking.
// Samples each bit at its centre and reports a byte, framing error or parity error as one-cycle pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_receiver_if.master bus,
  output uart_rx_state_t dbg_state
);

  localparam int BCNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF   = CLKS_PER_BIT / 2;

  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(HALF - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = ST_PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = ST_STOP;
`endif

  logic                      rx_s;
  uart_rx_state_t            state;
  logic [BCNT_W-1:0]         bcnt;
  logic [2:0]                dcnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] rdata_q;
  logic                      rvalid_q;
  logic                      ferr_q;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bcnt     <= '0;
      dcnt     <= '0;
      shreg    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          bcnt <= '0;
          if (!rx_s) state <= ST_START;
        end

        // A start bit must still be low half a bit in, otherwise it was a glitch.
        ST_START: begin
          if (bcnt == HALF_LAST) begin
            bcnt  <= '0;
            dcnt  <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end

        ST_DATA: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            dcnt  <= dcnt + 3'd1;
            if (dcnt == 3'd7) state <= AFTER_DATA;
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            state <= ST_STOP;
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (bcnt == BIT_LAST) begin
            bcnt <= '0;
            if (rx_s) begin
              rdata_q  <= shreg;
              rvalid_q <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              ferr_q <= 1'b1;
              state  <= ST_BREAK;
            end
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end

        // Wait out a held-low line so it cannot be mistaken for a stream of frames.
        ST_BREAK: begin
          bcnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          bcnt  <= '0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (state == ST_PARITY && bcnt == BIT_LAST) par_bit <= rx_s;
      if (state == ST_STOP && bcnt == BIT_LAST && rx_s)
        perr_q <= even_parity_mismatch(shreg, par_bit);
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.frame_err = ferr_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; expected bytes go into a queue
// that a negedge monitor drains whenever rvalid pulses.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int GAP = CPB * FRAME_BITS;

  typedef struct packed {
    logic [7:0]  data;
    logic        perr;
    logic [15:0] gap;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           rx  = 1'b1;
  uart_rx_state_t dbg_state;

  uart_receiver_if bus ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   ferr_seen = 0;
  int   ferr_exp  = 0;
  int   cyc       = 0;
  int   last_rv   = 0;
  logic prev_rv   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (bus.rvalid) begin
      check("rvalid_one_cycle", {31'd0, prev_rv}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rdata %0h, expected no byte", bus.rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", {24'd0, bus.rdata}, {24'd0, mon_e.data});
        check("parity_err", {31'd0, bus.parity_err}, {31'd0, mon_e.perr});
        if (mon_e.gap != 16'd0)
          check("frame_gap", cyc - last_rv, {16'd0, mon_e.gap});
      end
      last_rv = cyc;
    end
    if (bus.frame_err) begin
      ferr_seen++;
      check("frame_err_without_rvalid", {31'd0, bus.rvalid}, 32'd0);
    end
    if (bus.parity_err && !bus.rvalid) begin
      checks++;
      failures++;
      $display("FAIL parity_err_alone: got parity_err 1 expected 0 without rvalid");
    end
    prev_rv = bus.rvalid;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    hold(CPB);
`endif
    rx = stop;
    hold(CPB);
    rx = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic perr, input int gap);
    exp_q.push_back('{data: d, perr: perr, gap: 16'(gap)});
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    hold(3);
    check("reset_rdata", {24'd0, bus.rdata}, 32'd0);
    check("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b1;
    hold(5);

    // Clean byte
    expect_byte(8'hA5, 1'b0, 0);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    hold(2 * CPB);

    // Back-to-back frames with no idle gap
    expect_byte(8'h00, 1'b0, 0);
    expect_byte(8'hFF, 1'b0, GAP);
    expect_byte(8'h3C, 1'b0, GAP);
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    hold(2 * CPB);
    check("b2b_drained", exp_q.size(), 32'd0);

    // Glitch rejection
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(3 * CPB);
    check("glitch_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Stop-bit error followed by a long break
    ferr_exp++;
    send_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    hold(20 * CPB);
    check("break_state", {29'd0, dbg_state}, {29'd0, ST_BREAK});
    hold(20 * CPB);
    check("frame_err_count", ferr_seen, ferr_exp);
    rx = 1'b1;
    hold(2 * CPB);
    check("rdata_held", {24'd0, bus.rdata}, 32'h3C);
    check("idle_after_break", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    expect_byte(8'h12, 1'b0, 0);
    send_frame(8'h12, 1'b1, ^8'h12);
    hold(2 * CPB);

    // Reset after data bit 3 of 0x81; the rest of that frame is abandoned
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h81 >> i;
      hold(CPB);
    end
    rst = 1'b0;
    rx  = 1'b1;
    hold(1);
    rst = 1'b1;
    hold(2 * CPB);
    check("mid_reset_rdata", {24'd0, bus.rdata}, 32'd0);
    check("mid_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    expect_byte(8'h7E, 1'b0, 0);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    hold(2 * CPB);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity is 1
    expect_byte(8'h07, 1'b0, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_byte(8'h07, 1'b1, GAP);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(2 * CPB);
`endif

    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("frame_err_total", ferr_seen, ferr_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
